// File: rtl/resource_pool_lock_pkg.sv
// resource_pool_lock_pkg: shared sizing helpers and rpl_req field layout.
// Each requester lane in rpl_in is packed as {req, req_issue_id[ID_WIDTH-1:0], release_lock},
// i.e. the bit order of the rpl_req#(ID_WIDTH)::t struct, so lanes from that type connect directly.
package resource_pool_lock_pkg;

  // Bit position of release_lock and LSB of req_issue_id inside a lane; req is the lane MSB.
  localparam int unsigned RPL_REL_BIT = 0;
  localparam int unsigned RPL_ID_LSB  = 1;

  // Index width that stays at least 1 bit when there is a single element.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of one packed rpl_req lane.
  function automatic int unsigned rpl_w(input int unsigned id_width);
    return id_width + 2;
  endfunction

endpackage

// File: rtl/resource_pool_lock_age_picker.sv
// rpl_age_picker: combinational oldest-first selector over wrapping issue ids.
// a is older than b when (a-b) mod 2**ID_WIDTH has its MSB set; equal ids keep the lower index.
module rpl_age_picker
  import resource_pool_lock_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 4,
  localparam int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]               valid_i,
  input  logic [NUM_REQ-1:0][ID_WIDTH-1:0] id_i,
  output logic [IDX_W-1:0]                 oldest_o,
  output logic                             any_valid_o
);

  function automatic logic is_older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b);
    logic [ID_WIDTH-1:0] diff;
    diff = a - b;
    return diff[ID_WIDTH-1];
  endfunction

  logic [ID_WIDTH-1:0] best_id;

  // Linear scan: a later index only displaces the current best when strictly older.
  always_comb begin
    any_valid_o = 1'b0;
    oldest_o    = '0;
    best_id     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (valid_i[i] && (!any_valid_o || is_older(id_i[i], best_id))) begin
        any_valid_o = 1'b1;
        oldest_o    = IDX_W'(i);
        best_id     = id_i[i];
      end
    end
  end

endmodule

// File: rtl/resource_pool_lock.sv
// resource_pool_lock: responder side of the rpl_req lock protocol.
// Grants NUM_SLOTS identical resources to NUM_REQ requesters, oldest issue_id first,
// one allocation per cycle, held until the owner pulses release_lock.
// Optional build macro: RPL_PERF_CNT_EN adds perf_grants / perf_stall_cycles counters.
module resource_pool_lock
  import resource_pool_lock_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_SLOTS = 1,
  parameter int unsigned ID_WIDTH  = 4,
  localparam int unsigned REQ_W    = idx_w(NUM_REQ),
  localparam int unsigned SLOT_W   = idx_w(NUM_SLOTS),
  localparam int unsigned CNT_W    = $clog2(NUM_SLOTS + 1),
  localparam int unsigned RPL_W    = rpl_w(ID_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0][RPL_W-1:0]     rpl_in,
  output logic [NUM_REQ-1:0]                grant,
  output logic [NUM_REQ-1:0][SLOT_W-1:0]    grant_slot,
  output logic [NUM_SLOTS-1:0]              slot_busy,
  output logic [NUM_SLOTS-1:0][REQ_W-1:0]   slot_owner,
  output logic [CNT_W-1:0]                  free_count
`ifdef RPL_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_grants,
  output logic [31:0]                       perf_stall_cycles
`endif
);

  logic [NUM_REQ-1:0]                req_v, rel_v, pending;
  logic [NUM_REQ-1:0][ID_WIDTH-1:0]  req_id;
  logic [REQ_W-1:0]                  win_idx;
  logic                              any_pend;
  logic                              have_free, alloc;
  logic [SLOT_W-1:0]                 free_idx;

  logic [NUM_REQ-1:0]                grant_q, grant_d;
  logic [NUM_REQ-1:0][SLOT_W-1:0]    grant_slot_q, grant_slot_d;
  logic [NUM_SLOTS-1:0]              busy_q, busy_d;
  logic [NUM_SLOTS-1:0][REQ_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]                  free_count_q, free_count_d;

  // Unpack request lanes; owners are never pending, so req+release from an owner cannot re-win this edge.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      req_v[r]  = rpl_in[r][RPL_W-1];
      req_id[r] = rpl_in[r][RPL_ID_LSB +: ID_WIDTH];
      rel_v[r]  = rpl_in[r][RPL_REL_BIT];
    end
    pending = req_v & ~grant_q;
  end

  rpl_age_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .valid_i     (pending),
    .id_i        (req_id),
    .oldest_o    (win_idx),
    .any_valid_o (any_pend)
  );

  // Lowest-index free slot, looking only at registered occupancy so a slot freed this edge is not reused.
  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (!busy_q[s] && !have_free) begin
        have_free = 1'b1;
        free_idx  = SLOT_W'(s);
      end
    end
    alloc = have_free && any_pend;
  end

  // Next-state owner table: apply every owner release, then at most one allocation.
  always_comb begin
    grant_d      = grant_q;
    grant_slot_d = grant_slot_q;
    busy_d       = busy_q;
    owner_d      = owner_q;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (grant_q[r] && rel_v[r]) begin
        grant_d[r]                = 1'b0;
        grant_slot_d[r]           = '0;
        busy_d[grant_slot_q[r]]   = 1'b0;
        owner_d[grant_slot_q[r]]  = '0;
      end
    end
    if (alloc) begin
      grant_d[win_idx]      = 1'b1;
      grant_slot_d[win_idx] = free_idx;
      busy_d[free_idx]      = 1'b1;
      owner_d[free_idx]     = win_idx;
    end
    free_count_d = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      free_count_d = free_count_d + CNT_W'(!busy_d[s]);
    end
  end

  // Registered ownership state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= '0;
      grant_slot_q <= '0;
      busy_q       <= '0;
      owner_q      <= '0;
      free_count_q <= CNT_W'(NUM_SLOTS);
    end else begin
      grant_q      <= grant_d;
      grant_slot_q <= grant_slot_d;
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      free_count_q <= free_count_d;
    end
  end

  assign grant      = grant_q;
  assign grant_slot = grant_slot_q;
  assign slot_busy  = busy_q;
  assign slot_owner = owner_q;
  assign free_count = free_count_q;

`ifdef RPL_PERF_CNT_EN
  logic [31:0] perf_grants_q, perf_stall_q;

  // Saturating observation counters; they read arbitration signals but never feed back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grants_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (alloc && (perf_grants_q != '1)) perf_grants_q <= perf_grants_q + 32'd1;
      if (any_pend && (free_count_q == '0) && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_grants       = perf_grants_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_resource_pool_lock.sv
// Directed bench for resource_pool_lock: one single-slot and one dual-slot instance.
module tb_resource_pool_lock;

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0][5:0] rpl1, rpl2;

  logic [3:0]      g1, g2;
  logic [3:0][0:0] gs1, gs2;
  logic [0:0]      busy1;
  logic [1:0]      busy2;
  logic [0:0][1:0] own1;
  logic [1:0][1:0] own2;
  logic [0:0]      fc1;
  logic [1:0]      fc2;
`ifdef RPL_PERF_CNT_EN
  logic [31:0] pg1, ps1, pg2, ps2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  resource_pool_lock #(.NUM_REQ(4), .NUM_SLOTS(1), .ID_WIDTH(4)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rpl_in     (rpl1),
    .grant      (g1),
    .grant_slot (gs1),
    .slot_busy  (busy1),
    .slot_owner (own1),
    .free_count (fc1)
`ifdef RPL_PERF_CNT_EN
    ,
    .perf_grants       (pg1),
    .perf_stall_cycles (ps1)
`endif
  );

  resource_pool_lock #(.NUM_REQ(4), .NUM_SLOTS(2), .ID_WIDTH(4)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rpl_in     (rpl2),
    .grant      (g2),
    .grant_slot (gs2),
    .slot_busy  (busy2),
    .slot_owner (own2),
    .free_count (fc2)
`ifdef RPL_PERF_CNT_EN
    ,
    .perf_grants       (pg2),
    .perf_stall_cycles (ps2)
`endif
  );

  function automatic logic [5:0] pk(input logic r, input logic [3:0] id, input logic rel);
    return {r, id, rel};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rpl1  = '0;
    rpl2  = '0;
    repeat (2) step();
    chk("rst_grant1", 32'(g1), 32'h0);
    chk("rst_gslot1", 32'(gs1), 32'h0);
    chk("rst_busy1",  32'(busy1), 32'h0);
    chk("rst_owner1", 32'(own1), 32'h0);
    chk("rst_free1",  32'(fc1), 32'h1);
    chk("rst_grant2", 32'(g2), 32'h0);
    chk("rst_free2",  32'(fc2), 32'h2);
    rst_n = 1'b1;
    step();
    chk("idle_grant", 32'(g1), 32'h0);

    // Single request, one-cycle grant latency
    rpl1[0] = pk(1'b1, 4'd3, 1'b0);
    step();
    chk("t1_grant", 32'(g1), 32'h1);
    chk("t1_gslot", 32'(gs1[0]), 32'h0);
    chk("t1_owner", 32'(own1[0]), 32'h0);
    chk("t1_busy",  32'(busy1), 32'h1);
    chk("t1_free",  32'(fc1), 32'h0);

    // Owner drops req, then pulses release
    rpl1[0] = pk(1'b0, 4'd3, 1'b0);
    step();
    chk("t4_hold", 32'(g1), 32'h1);
    rpl1[0] = pk(1'b0, 4'd3, 1'b1);
    step();
    chk("t4_rel_grant", 32'(g1), 32'h0);
    chk("t4_rel_free",  32'(fc1), 32'h1);
    chk("t4_rel_busy",  32'(busy1), 32'h0);

    // Non-owner release ignored; release + new req at same edge waits a cycle
    rpl1[0] = pk(1'b1, 4'd3, 1'b0);
    step();
    chk("t5_regrant", 32'(g1), 32'h1);
    rpl1[2] = pk(1'b1, 4'd7, 1'b0);
    step();
    chk("t5_stall", 32'(g1), 32'h1);
    rpl1[2] = pk(1'b1, 4'd7, 1'b1);
    step();
    chk("t5_nonown_grant", 32'(g1), 32'h1);
    chk("t5_nonown_owner", 32'(own1[0]), 32'h0);
    chk("t5_nonown_free",  32'(fc1), 32'h0);
    rpl1[2] = pk(1'b1, 4'd7, 1'b0);
    rpl1[0] = pk(1'b0, 4'd3, 1'b1);
    step();
    chk("t5_nobypass_grant", 32'(g1), 32'h0);
    chk("t5_nobypass_free",  32'(fc1), 32'h1);
    rpl1[0] = '0;
    step();
    chk("t5_y_grant", 32'(g1), 32'h4);
    chk("t5_y_owner", 32'(own1[0]), 32'h2);
    rpl1[2] = pk(1'b0, 4'd7, 1'b1);
    step();
    chk("t5_y_rel", 32'(g1), 32'h0);
    rpl1[2] = '0;

    // Oldest first: id 2 beats id 5
    rpl1[0] = pk(1'b1, 4'd5, 1'b0);
    rpl1[2] = pk(1'b1, 4'd2, 1'b0);
    step();
    chk("t2_first", 32'(g1), 32'h4);
    rpl1[2] = pk(1'b0, 4'd2, 1'b1);
    step();
    chk("t2_gap", 32'(g1), 32'h0);
    rpl1[2] = '0;
    step();
    chk("t2_second", 32'(g1), 32'h1);
    rpl1[0] = pk(1'b0, 4'd5, 1'b1);
    step();
    chk("t2_rel", 32'(g1), 32'h0);
    rpl1[0] = '0;

    // Wrap: id 15 is older than id 1
    rpl1[1] = pk(1'b1, 4'd15, 1'b0);
    rpl1[3] = pk(1'b1, 4'd1, 1'b0);
    step();
    chk("t3_wrap_grant", 32'(g1), 32'h2);
    chk("t3_wrap_owner", 32'(own1[0]), 32'h1);
    rpl1[1] = pk(1'b0, 4'd15, 1'b1);
    step();
    chk("t3_rel", 32'(g1), 32'h0);
    rpl1[1] = '0;
    step();
    chk("t3_next_grant", 32'(g1), 32'h8);
    chk("t3_next_owner", 32'(own1[0]), 32'h3);
    rpl1[3] = pk(1'b0, 4'd1, 1'b1);
    step();
    chk("t3_rel2", 32'(g1), 32'h0);
    rpl1[3] = '0;

    // Equal ids tie to lower index; req+release from owner: release wins, then re-enters
    rpl1[1] = pk(1'b1, 4'd4, 1'b0);
    rpl1[2] = pk(1'b1, 4'd4, 1'b0);
    step();
    chk("tie_grant", 32'(g1), 32'h2);
    rpl1[1] = pk(1'b1, 4'd4, 1'b1);
    step();
    chk("relwins_grant", 32'(g1), 32'h0);
    rpl1[1] = pk(1'b1, 4'd4, 1'b0);
    step();
    chk("reenter_grant", 32'(g1), 32'h2);
    rpl1[1] = pk(1'b0, 4'd4, 1'b1);
    rpl1[2] = '0;
    step();
    chk("final_rel", 32'(g1), 32'h0);
    rpl1[1] = '0;
    step();
    chk("final_free", 32'(fc1), 32'h1);
`ifdef RPL_PERF_CNT_EN
    chk("perf_grants", pg1, 32'd9);
    chk("perf_stall",  ps1, 32'd6);
`endif

    // Two slots: fill both, then async reset mid-ownership
    rpl2[0] = pk(1'b1, 4'd1, 1'b0);
    rpl2[3] = pk(1'b1, 4'd2, 1'b0);
    step();
    chk("t6_g_a",    32'(g2), 32'h1);
    chk("t6_gslot0", 32'(gs2[0]), 32'h0);
    chk("t6_free_a", 32'(fc2), 32'h1);
    step();
    chk("t6_g_b",    32'(g2), 32'h9);
    chk("t6_gslot3", 32'(gs2[3]), 32'h1);
    chk("t6_owner1", 32'(own2[1]), 32'h3);
    chk("t6_owner0", 32'(own2[0]), 32'h0);
    chk("t6_free_b", 32'(fc2), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(g2), 32'h0);
    chk("t6_rst_free",  32'(fc2), 32'h2);
    chk("t6_rst_busy",  32'(busy2), 32'h0);
    chk("t6_rst_owner", 32'(own2), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_rearb_a", 32'(g2), 32'h1);
    step();
    chk("t6_rearb_b", 32'(g2), 32'h9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
